secure_unlock: RTL and testbench

SECURE_UNLOCK -- requirements
Module: secure_unlock

---
 rtl/secure_unlock.sv | 146 ++++++++++++++
 tb/tb_secure_unlock.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/secure_unlock.sv
// Key-entry unlock FSM: collects KEY_LEN bytes, unlocks on a match, and locks out after MAX_FAIL misses.
// Optional auto-relock after UNLOCK_TIMEOUT cycles when SECURE_UNLOCK_TIMEOUT_EN is defined.
module secure_unlock #(
   parameter int          KEY_LEN        = 4,
   parameter logic [63:0] KEY            = 64'h0000_0000_A5C3_0F01,
   parameter int          MAX_FAIL       = 3,
   parameter int          LOCK_CYCLES    = 16,
   parameter int          UNLOCK_TIMEOUT = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       relock,
   output logic       secure,
   output logic       locked_out,
   output logic [3:0] fail_cnt
);

   typedef enum logic [1:0] {
      COLLECT  = 2'd0,
      CHECK    = 2'd1,
      UNLOCKED = 2'd2,
      LOCKOUT  = 2'd3
   } state_t;

   localparam logic [2:0]  LAST_IDX  = 3'(KEY_LEN - 1);
   localparam logic [3:0]  MAX_FAILS = 4'(MAX_FAIL);
   localparam logic [15:0] LOCK_LOAD = 16'(LOCK_CYCLES - 1);

   state_t      state;
   logic [2:0]  idx;
   logic        mismatch;
   logic [15:0] lock_cnt;
   logic        ready_q;
   logic        accept;
   logic [2:0]  rev_idx;
   logic [7:0]  exp_byte;
   logic [3:0]  fail_inc;

`ifdef SECURE_UNLOCK_TIMEOUT_EN
   localparam logic [31:0] TMO_LOAD = 32'(UNLOCK_TIMEOUT - 1);
   logic [31:0] tmo_cnt;
`endif

   // Key bytes are entered most significant first, so byte idx sits KEY_LEN-1-idx bytes up.
   assign rev_idx  = LAST_IDX - idx;
   assign exp_byte = 8'(KEY >> {rev_idx, 3'b000});
   assign fail_inc = fail_cnt + 4'd1;

   // ready_q tracks "next state is COLLECT"; rst gates it so the port is low throughout reset.
   assign in_ready = ready_q & ~rst;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= COLLECT;
         idx        <= 3'd0;
         mismatch   <= 1'b0;
         fail_cnt   <= 4'd0;
         lock_cnt   <= 16'd0;
         secure     <= 1'b0;
         locked_out <= 1'b0;
         ready_q    <= 1'b1;
`ifdef SECURE_UNLOCK_TIMEOUT_EN
         tmo_cnt    <= 32'd0;
`endif
      end else begin
         case (state)
            COLLECT: begin
               // relock wins over a byte arriving in the same cycle; that byte is dropped.
               if (relock) begin
                  idx      <= 3'd0;
                  mismatch <= 1'b0;
               end else if (accept) begin
                  if (in_data != exp_byte) begin
                     mismatch <= 1'b1;
                  end
                  if (idx == LAST_IDX) begin
                     idx     <= 3'd0;
                     state   <= CHECK;
                     ready_q <= 1'b0;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end

            CHECK: begin
               mismatch <= 1'b0;
               if (!mismatch) begin
                  fail_cnt <= 4'd0;
                  state    <= UNLOCKED;
                  secure   <= 1'b1;
`ifdef SECURE_UNLOCK_TIMEOUT_EN
                  tmo_cnt  <= TMO_LOAD;
`endif
               end else if (fail_inc >= MAX_FAILS) begin
                  fail_cnt   <= MAX_FAILS;
                  state      <= LOCKOUT;
                  locked_out <= 1'b1;
                  lock_cnt   <= LOCK_LOAD;
               end else begin
                  fail_cnt <= fail_inc;
                  state    <= COLLECT;
                  ready_q  <= 1'b1;
               end
            end

            UNLOCKED: begin
               if (relock) begin
                  state   <= COLLECT;
                  secure  <= 1'b0;
                  ready_q <= 1'b1;
`ifdef SECURE_UNLOCK_TIMEOUT_EN
               end else if (tmo_cnt == 32'd0) begin
                  state   <= COLLECT;
                  secure  <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt - 32'd1;
`endif
               end
            end

            LOCKOUT: begin
               if (lock_cnt == 16'd0) begin
                  state      <= COLLECT;
                  locked_out <= 1'b0;
                  fail_cnt   <= 4'd0;
                  ready_q    <= 1'b1;
               end else begin
                  lock_cnt <= lock_cnt - 16'd1;
               end
            end

            default: begin
               state   <= COLLECT;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secure_unlock.sv
// Testbench for secure_unlock: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based model of the unlock rules.
module tb_secure_unlock;

   localparam int KEY_LEN     = 4;
   localparam int MAX_FAIL    = 3;
   localparam int LOCK_CYCLES = 16;
   localparam int TIMEOUT     = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_ready;
   logic       relock = 1'b0;
   logic       secure;
   logic       locked_out;
   logic [3:0] fail_cnt;

   int total = 0;
   int bad   = 0;

   logic [7:0] key_bytes [KEY_LEN] = '{8'hA5, 8'hC3, 8'h0F, 8'h01};

   secure_unlock dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .relock    (relock),
      .secure    (secure),
      .locked_out(locked_out),
      .fail_cnt  (fail_cnt)
   );

   always #5 clk = ~clk;

   // Model: bytes entered so far, a pending verdict, unlock flag, lockout cycles left, failures.
   logic [7:0] m_entry [$];
   bit m_check     = 0;
   bit m_secure    = 0;
   int m_lock_left = 0;
   int m_fails     = 0;
   int m_age       = 0;
   bit model_valid = 0;

   function automatic bit modelCollecting();
      return !m_check && !m_secure && (m_lock_left == 0);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_entry.delete();
         m_check     = 0;
         m_secure    = 0;
         m_lock_left = 0;
         m_fails     = 0;
         m_age       = 0;
         model_valid = 1;
      end else if (m_check) begin
         bit ok;
         ok = 1;
         for (int i = 0; i < KEY_LEN; i++) begin
            if (m_entry[i] != key_bytes[i]) ok = 0;
         end
         m_entry.delete();
         m_check = 0;
         if (ok) begin
            m_secure = 1;
            m_fails  = 0;
            m_age    = 0;
         end else begin
            m_fails++;
            if (m_fails == MAX_FAIL) m_lock_left = LOCK_CYCLES;
         end
      end else if (m_secure) begin
         if (relock) begin
            m_secure = 0;
         end else begin
`ifdef SECURE_UNLOCK_TIMEOUT_EN
            m_age++;
            if (m_age == TIMEOUT) m_secure = 0;
`endif
         end
      end else if (m_lock_left > 0) begin
         m_lock_left--;
         if (m_lock_left == 0) m_fails = 0;
      end else begin
         if (relock) begin
            m_entry.delete();
         end else if (in_valid) begin
            m_entry.push_back(in_data);
            if (m_entry.size() == KEY_LEN) m_check = 1;
         end
      end
   end

   task automatic compareVal(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (model_valid) begin
         compareVal("model.in_ready", {7'd0, in_ready}, {7'd0, (!rst && modelCollecting())});
         compareVal("model.secure", {7'd0, secure}, {7'd0, m_secure});
         compareVal("model.locked_out", {7'd0, locked_out}, {7'd0, (m_lock_left > 0)});
         compareVal("model.fail_cnt", {4'd0, fail_cnt}, 8'(m_fails));
      end
   end

   // One clock cycle of stimulus; inputs change 2 time units after the rising edge.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
      in_valid = v;
      in_data  = d;
      relock   = r;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      relock   = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic r, input logic s, input logic l,
                              input logic [3:0] f);
      #1;
      compareVal({name, ".in_ready"}, {7'd0, in_ready}, {7'd0, r});
      compareVal({name, ".secure"}, {7'd0, secure}, {7'd0, s});
      compareVal({name, ".locked_out"}, {7'd0, locked_out}, {7'd0, l});
      compareVal({name, ".fail_cnt"}, {4'd0, fail_cnt}, {4'd0, f});
   endtask

   task automatic sendKey(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3);
      applyStimulus(1'b1, b0, 1'b0);
      applyStimulus(1'b1, b1, 1'b0);
      applyStimulus(1'b1, b2, 1'b0);
      applyStimulus(1'b1, b3, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset_held", 1'b0, 1'b0, 1'b0, 4'd0);
      rst = 1'b0;
      checkOutput("reset_release", 1'b1, 1'b0, 1'b0, 4'd0);

      // Correct key, then relock.
      sendKey(8'hA5, 8'hC3, 8'h0F, 8'h01);
      checkOutput("good_check", 1'b0, 1'b0, 1'b0, 4'd0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("good_unlock", 1'b0, 1'b1, 1'b0, 4'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("good_relock", 1'b1, 1'b0, 1'b0, 4'd0);

      // Wrong entry, then two more to reach lockout.
      sendKey(8'hA5, 8'hC3, 8'h0F, 8'h02);
      checkOutput("bad1_check", 1'b0, 1'b0, 1'b0, 4'd0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("bad1_done", 1'b1, 1'b0, 1'b0, 4'd1);
      sendKey(8'h11, 8'hC3, 8'h0F, 8'h01);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("bad2_done", 1'b1, 1'b0, 1'b0, 4'd2);
      sendKey(8'hA5, 8'hC3, 8'h0E, 8'h01);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("lock_c1", 1'b0, 1'b0, 1'b1, 4'd3);
      for (int i = 2; i <= LOCK_CYCLES; i++) begin
         if (i <= 5) applyStimulus(1'b1, key_bytes[i-2], (i == 5));
         else applyStimulus(1'b0, 8'h00, 1'b0);
         checkOutput($sformatf("lock_c%0d", i), 1'b0, 1'b0, 1'b1, 4'd3);
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("lock_exit", 1'b1, 1'b0, 1'b0, 4'd0);

      // Abort a partial entry with relock.
      applyStimulus(1'b1, 8'hA5, 1'b0);
      applyStimulus(1'b1, 8'hC3, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("abort", 1'b1, 1'b0, 1'b0, 4'd0);
      sendKey(8'hA5, 8'hC3, 8'h0F, 8'h01);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("abort_unlock", 1'b0, 1'b1, 1'b0, 4'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Reset in the middle of an entry.
      applyStimulus(1'b1, 8'hA5, 1'b0);
      applyStimulus(1'b1, 8'hC3, 1'b0);
      rst = 1'b1;
      checkOutput("midrst_held", 1'b0, 1'b0, 1'b0, 4'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      checkOutput("midrst_release", 1'b1, 1'b0, 1'b0, 4'd0);
      sendKey(8'h0F, 8'h01, 8'hA5, 8'hC3);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("midrst_fail", 1'b1, 1'b0, 1'b0, 4'd1);

      // Unlock and hold without relock.
      sendKey(8'hA5, 8'hC3, 8'h0F, 8'h01);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("hold_c1", 1'b0, 1'b1, 1'b0, 4'd0);
      for (int i = 2; i <= 110; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0);
`ifdef SECURE_UNLOCK_TIMEOUT_EN
         checkOutput($sformatf("hold_c%0d", i), (i > TIMEOUT), (i <= TIMEOUT), 1'b0, 4'd0);
`else
         checkOutput($sformatf("hold_c%0d", i), 1'b0, 1'b1, 1'b0, 4'd0);
`endif
      end
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Randomized traffic, checked by the model on every cycle.
      for (int n = 0; n < 4000; n++) begin
         logic       v;
         logic [7:0] d;
         logic       r;
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 8) d = key_bytes[m_entry.size() % KEY_LEN];
         else d = 8'($urandom_range(0, 255));
         r = ($urandom_range(0, 23) == 0);
         if ($urandom_range(0, 299) == 0) rst = 1'b1;
         applyStimulus(v, d, r);
         rst = 1'b0;
      end
      applyStimulus(1'b0, 8'h00, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
